gated_reg_bist: RTL
===================

# gated_reg_bist

Built-in self-test sequencer and checker for the enabled-register (clock-gating) datapath cells. It drives a WIDTH-bit register under test through its D_IN/EN inputs and samples its D_OUT output. Stimulus is a repeatable LFSR sequence of data and enable values. A shadow model of the register predicts D_OUT and mismatches are counted. It sits beside each gated register bank and replaces the simulation-only directed bench with a synthesizable on-chip check.

## Interface
- WIDTH, 4, data width of the register under test; legal range 1..8
- NUM_VECTORS, 16, number of stimulus vectors per run; legal range 1..255
- SEED, 8'hA5, LFSR load value at START; must be nonzero
- CLK  in  1  single clock, rising edge; the register under test uses the same CLK
- RST  in  1  reset; synchronous, active-high
- START  in  1  run request; sampled only in IDLE and DONE
- DUT_D_OUT  in  WIDTH  D_OUT of the register under test
- BIST_D_IN  out  WIDTH  drives D_IN of the register under test; registered
- BIST_EN  out  1  drives EN of the register under test; registered
- BUSY  out  1  high in RUN and DRAIN
- DONE  out  1  level; high in DONE state until next START or RST
- PASS  out  1  valid when DONE=1; 1 iff ERR_CNT==0
- ERR_CNT  out  8  mismatch count, saturates at 8'hFF

## Operation
- Reset, synchronously on RST=1:
  - outputs: BIST_D_IN=0, BIST_EN=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0
  - internal: state=IDLE, LFSR=SEED, vector index=0, shadow model=0
- RST mid-run aborts immediately; no DONE is produced.
- States and transitions:
  - IDLE -> RUN on START=1.
  - RUN: stays for exactly NUM_VECTORS cycles, then -> DRAIN.
  - DRAIN: one cycle, then -> DONE.
  - DONE -> RUN on START=1.
  - START is ignored in RUN and DRAIN.
- On entry to RUN:
  - LFSR=SEED, index=0, ERR_CNT=0, DONE=0, PASS=0.
  - The same SEED gives an identical sequence on every run.
- LFSR: 8-bit Fibonacci, next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}. It advances once per RUN cycle.
- Vector k is built from the LFSR value after k advances:
  - d_k = lfsr[WIDTH-1:0]
  - e_k = lfsr[7] for k>0; e_0 is forced to 1
  - Forcing e_0=1 defines the register content despite the unreset DUT, so every compare is valid.
- Shadow model update: exp_k = e_k ? d_k : exp_{k-1}.
- Check: DUT_D_OUT is compared with exp_k one cycle after vector k was captured by the register. On mismatch ERR_CNT increments, saturating at 255.
- DRAIN: BIST_EN=0, BIST_D_IN holds its last value, and the final compare (vector N-1) completes.
- DONE state:
  - BIST_EN=0.
  - PASS=(ERR_CNT==0), registered on DRAIN -> DONE.
  - ERR_CNT is frozen.

## Timing
- Edge E0 samples START=1 in IDLE. Vector 0 is on BIST_D_IN/BIST_EN during the cycle after E0.
- At edge Ek (k=1..N, N=NUM_VECTORS) the register captures vector k-1. State moves RUN -> DRAIN at E_N.
- Edges E2..E_{N+1} perform the compares of vectors 0..N-1.
- At E_{N+1}: DONE=1, BUSY=0, and PASS/ERR_CNT are final. Latency from START edge to DONE is N+1 cycles.
- BUSY rises with the first vector after E0 and falls together with DONE rising.
- START held high continuously: exactly one run per DONE visit. DONE is visible for at least one cycle before restart.
- ERR_CNT is not guaranteed final before DONE=1.
- Reset has priority over START in the same cycle.
- NUM_VECTORS=1 still yields a valid run: one vector, DRAIN, DONE after 2 cycles.

## Test plan
- Correct 4-bit enabled register, defaults: START pulse -> BIST_D_IN/BIST_EN = 4'h5/1, 4'hA/0, 4'h5/1 in the first three RUN cycles; DONE=1 at E17; PASS=1; ERR_CNT=0.
- DUT_D_OUT[0] stuck at 0 -> DONE at E17, PASS=0, ERR_CNT equals the bench model's count of exp_k with bit0=1 (nonzero, since exp_0=4'h5).
- DUT ignoring EN (loads every cycle) -> ERR_CNT equals count of k with e_k=0 and d_k!=exp_k; the first mismatch is counted at E3 (vector 1: DUT 4'hA vs exp 4'h5).
- RST asserted at E8 mid-run -> next cycle all outputs zero, state IDLE, no DONE; a fresh START reproduces the identical vector sequence and result.
- START held high from reset for 60 cycles -> DONE/restart cycles repeat every 18 cycles. Each DONE window lasts 1 cycle with PASS=1. START pulses during RUN produce no effect.
- Forced mismatch on every compare with NUM_VECTORS=255 plus an extra DUT glitch -> ERR_CNT saturates at 8'hFF, PASS=0.

Source files
------------

// File: rtl/gated_reg_bist.sv
// On-chip BIST for an enabled (clock-gated) register: LFSR-driven D/EN stimulus, shadow-model
// prediction of D_OUT and a saturating mismatch counter.
module gated_reg_bist #(
   parameter int unsigned WIDTH       = 4,
   parameter int unsigned NUM_VECTORS = 16,
   parameter logic [7:0]  SEED        = 8'hA5
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] DUT_D_OUT,
   output logic [WIDTH-1:0] BIST_D_IN,
   output logic             BIST_EN,
   output logic             BUSY,
   output logic             DONE,
   output logic             PASS,
   output logic [7:0]       ERR_CNT
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   localparam logic [7:0] LastIdx = 8'(NUM_VECTORS - 1);

   state_e           state_q, state_d;
   logic [7:0]       lfsr_q, lfsr_d;
   logic [7:0]       idx_q, idx_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic [WIDTH-1:0] d_in_q, d_in_d;
   logic             en_q, en_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic             cmp_valid_q, cmp_valid_d;
   logic [7:0]       err_cnt_q, err_cnt_d;
   logic             mismatch;

   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   always_comb begin
      state_d     = state_q;
      lfsr_d      = lfsr_q;
      idx_d       = idx_q;
      shadow_d    = shadow_q;
      d_in_d      = d_in_q;
      en_d        = en_q;
      busy_d      = busy_q;
      done_d      = done_q;
      pass_d      = pass_q;
      err_cnt_d   = err_cnt_q;
      // A vector driven during a RUN cycle is captured at the next edge and checked one edge later.
      cmp_valid_d = (state_q == StRun);

      mismatch = cmp_valid_q && (DUT_D_OUT != shadow_q);
      if (mismatch && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end

      if (state_q == StRun) begin
         shadow_d = en_q ? d_in_q : shadow_q;
      end

      unique case (state_q)
         StIdle, StDone: begin
            if (START) begin
               state_d   = StRun;
               idx_d     = 8'd0;
               d_in_d    = SEED[WIDTH-1:0];
               en_d      = 1'b1;  // vector 0 always loads, so the unreset register gets defined
               lfsr_d    = lfsr_next(SEED);
               busy_d    = 1'b1;
               done_d    = 1'b0;
               pass_d    = 1'b0;
               err_cnt_d = 8'd0;
            end
         end
         StRun: begin
            if (idx_q == LastIdx) begin
               state_d = StDrain;
               en_d    = 1'b0;
            end else begin
               idx_d  = idx_q + 8'd1;
               d_in_d = lfsr_q[WIDTH-1:0];
               en_d   = lfsr_q[7];
               lfsr_d = lfsr_next(lfsr_q);
            end
         end
         StDrain: begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_cnt_d == 8'd0);
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= StIdle;
         lfsr_q      <= SEED;
         idx_q       <= 8'd0;
         shadow_q    <= '0;
         d_in_q      <= '0;
         en_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         cmp_valid_q <= 1'b0;
         err_cnt_q   <= 8'd0;
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         idx_q       <= idx_d;
         shadow_q    <= shadow_d;
         d_in_q      <= d_in_d;
         en_q        <= en_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         cmp_valid_q <= cmp_valid_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign BIST_D_IN = d_in_q;
   assign BIST_EN   = en_q;
   assign BUSY      = busy_q;
   assign DONE      = done_q;
   assign PASS      = pass_q;
   assign ERR_CNT   = err_cnt_q;

endmodule
